io_btn_debounce: RTL and testbench

Input conditioner for the board push-buttons. It sits directly upstream of the single-cycle core's `i_io_btn` port. Per channel, it synchronizes the raw active-low KEY inputs into `i_clk`, filters contact bounce with a consecutive-cycle counter, and presents a clean active-high level. It also produces a one-cycle press pulse. An optional auto-repeat mode re-fires the press pulse while a button is held.

---
 rtl/io_btn_debounce.sv | 117 +++++++++++
 tb/tb_io_btn_debounce.sv | 122 ++++++++++++
 2 files changed

// File: rtl/io_btn_debounce.sv
// Push-button conditioner: 2-flop sync, consecutive-cycle debounce, press pulse.
// Define IO_BTN_REPEAT_EN to re-fire the press pulse while a button is held.
module io_btn_debounce #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    output logic [NUM_BTN-1:0] o_btn,
    output logic [NUM_BTN-1:0] o_btn_press
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] s1_q, s2_q;
    logic [NUM_BTN-1:0] st_q, st_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] pressed;
    logic [NUM_BTN-1:0] rise;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];

    assign pressed = ~s2_q;

    always_comb begin
        st_d = st_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (pressed[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = pressed[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = st_d & ~st_q;

`ifdef IO_BTN_REPEAT_EN
    localparam int RPT_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W   = $clog2(RPT_SPAN + 1);
    localparam logic [RCNT_W-1:0] DLY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PER_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic [RCNT_W-1:0]  rcnt_q [NUM_BTN];
    logic [RCNT_W-1:0]  rcnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rep_q, rep_d;

    // rep_q marks a channel past its first repeat; it then fires every REPEAT_PERIOD.
    always_comb begin
        press_d = rise;
        rep_d   = rep_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            rcnt_d[i] = '0;
            if (st_q[i] && st_d[i]) begin
                if (rcnt_q[i] == (rep_q[i] ? PER_LAST : DLY_LAST)) begin
                    press_d[i] = 1'b1;
                    rep_d[i]   = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + 1'b1;
                end
            end else begin
                rep_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rep_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            rep_q <= rep_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end
`else
    logic unused_cfg;

    assign press_d    = rise;
    assign unused_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_q    <= '1;
            s2_q    <= '1;
            st_q    <= '0;
            press_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= i_btn_raw;
            s2_q    <= s1_q;
            st_q    <= st_d;
            press_q <= press_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign o_btn       = st_q;
    assign o_btn_press = press_q;

endmodule

// File: tb/tb_io_btn_debounce.sv
// Directed bench for io_btn_debounce with DEBOUNCE_CYCLES = 4.
// Repeat sequence is exercised only when IO_BTN_REPEAT_EN is defined.
module tb_io_btn_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn;
    logic [3:0] btn_press;

    int n_chk  = 0;
    int n_pass = 0;

    io_btn_debounce #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn_raw  (btn_raw),
        .o_btn      (btn),
        .o_btn_press(btn_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: btn/press got %b_%b expected %b_%b at %0t",
                     tag, obs[7:4], obs[3:0], exp[7:4], exp[3:0], $time);
        end
    endtask

    // Advance n edges, checking {o_btn, o_btn_press} 1 time unit after each.
    task automatic hold(input int n, input logic [3:0] eb, input logic [3:0] ep, input string tag);
        repeat (n) begin
            @(posedge clk);
            #1;
            check(tag, {btn, btn_press}, {eb, ep});
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = 4'hF;
        hold(5, 4'h0, 4'h0, "reset");
        rst_n = 1'b1;
        hold(50, 4'h0, 4'h0, "idle");

        // Single press on channel 0, then release.
        btn_raw = 4'b1110;
        hold(5, 4'h0, 4'h0, "t2_wait");
        hold(1, 4'h1, 4'h1, "t2_press");
        hold(1, 4'h1, 4'h0, "t2_pulse_end");
        hold(3, 4'h1, 4'h0, "t2_held");
        btn_raw = 4'hF;
        hold(5, 4'h1, 4'h0, "t2_rel_wait");
        hold(1, 4'h0, 4'h0, "t2_rel");
        hold(3, 4'h0, 4'h0, "t2_idle");

        // 3-cycle glitch is rejected; 4-cycle pulse is accepted for 4 cycles.
        btn_raw = 4'b1101;
        hold(3, 4'h0, 4'h0, "t3_glitch_low");
        btn_raw = 4'hF;
        hold(10, 4'h0, 4'h0, "t3_glitch_rej");
        btn_raw = 4'b1101;
        hold(4, 4'h0, 4'h0, "t3_pulse_low");
        btn_raw = 4'hF;
        hold(1, 4'h0, 4'h0, "t3_pulse_wait");
        hold(1, 4'h2, 4'h2, "t3_pulse_acc");
        hold(3, 4'h2, 4'h0, "t3_pulse_lvl");
        hold(1, 4'h0, 4'h0, "t3_pulse_rel");
        hold(4, 4'h0, 4'h0, "t3_idle");

        // Simultaneous press on channels 1 and 3.
        btn_raw = 4'b0101;
        hold(5, 4'h0, 4'h0, "t4_wait");
        hold(1, 4'hA, 4'hA, "t4_press");
        hold(14, 4'hA, 4'h0, "t4_held");
        btn_raw = 4'hF;
        hold(5, 4'hA, 4'h0, "t4_rel_wait");
        hold(1, 4'h0, 4'h0, "t4_rel");
        hold(3, 4'h0, 4'h0, "t4_idle");

        // Reset in the middle of a hold on channel 2.
        btn_raw = 4'b1011;
        hold(5, 4'h0, 4'h0, "t5_wait");
        hold(1, 4'h4, 4'h4, "t5_press");
        hold(3, 4'h4, 4'h0, "t5_held");
        rst_n = 1'b0;
        hold(2, 4'h0, 4'h0, "t5_rst");
        rst_n = 1'b1;
        hold(5, 4'h0, 4'h0, "t5_rewait");
        hold(1, 4'h4, 4'h4, "t5_repress");
        hold(1, 4'h4, 4'h0, "t5_reheld");
        btn_raw = 4'hF;
        hold(5, 4'h4, 4'h0, "t5_rel_wait");
        hold(1, 4'h0, 4'h0, "t5_rel");

`ifdef IO_BTN_REPEAT_EN
        // Held channel 0: pulses at P, P+8, P+11, P+14, P+17; release lands at P+20.
        hold(3, 4'h0, 4'h0, "rpt_idle");
        btn_raw = 4'b1110;
        hold(5, 4'h0, 4'h0, "rpt_wait");
        hold(1, 4'h1, 4'h1, "rpt_first");
        for (int k = 1; k < 20; k++) begin
            hold(1, 4'h1, (k == 8 || k == 11 || k == 14 || k == 17) ? 4'h1 : 4'h0, "rpt_hold");
            if (k == 14) btn_raw = 4'hF;
        end
        hold(10, 4'h0, 4'h0, "rpt_after_rel");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
